// File: rtl/serial_digit_adder_if.sv
// Start/done handshake bundle for serial_digit_adder.
// Optional subtract port present when SERIAL_DIGIT_ADDER_SUB_EN is defined.
interface serial_digit_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: sums two WIDTH-bit operands plus carry-in, DIGIT bits
// per clock, through one DIGIT-bit adder slice and a registered carry.
// Result and carry-out appear K = WIDTH/DIGIT edges after the start edge.
// Define SERIAL_DIGIT_ADDER_SUB_EN to add a 'sub' input computing a - b - cin
// (cout then reads as not-borrow).
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_digit_adder_if.slave bus
);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_digit_adder: DIGIT must be >= 1 and divide WIDTH (>= 1)");
    end
  endgenerate

  localparam int K  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, psum, psum_next;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             busy_c;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             done_r;

  assign bus.busy = busy_c;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

  assign last = (cnt == CW'(K - 1));

  // Operand conditioning at capture: subtraction is a + ~b + ~cin.
  always_comb begin
    b_in = bus.b;
    c_in = bus.cin;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    if (bus.sub) begin
      b_in = ~bus.b;
      c_in = ~bus.cin;
    end
`endif
  end

  // One DIGIT-wide full-adder slice; result digit enters the top of the partial sum.
  always_comb begin
    slice     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
    psum_next = (psum >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and busy decode.
  always_comb begin
    next_state = state;
    busy_c     = 1'b0;
    case (state)
      IDLE: if (bus.start) next_state = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, shift one digit per RUN cycle,
  // publish sum/cout only on the final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      psum   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= b_in;
            carry <= c_in;
            psum  <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          psum  <= psum_next;
          carry <= slice[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_r  <= psum_next;
            cout_r <= slice[DIGIT];
            done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench for serial_digit_adder: three instances (8/1, 8/4, 1/1).
// Stimulus pushes expected {sum, cout, done edge}; a monitor pops on done.
module tb_serial_digit_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    int         edge_no;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  serial_digit_adder_if #(.WIDTH(8)) if0 ();
  serial_digit_adder_if #(.WIDTH(8)) if1 ();
  serial_digit_adder_if #(.WIDTH(1)) if2 ();

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  serial_digit_adder #(.WIDTH(8), .DIGIT(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_digit_adder #(.WIDTH(1), .DIGIT(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(string name, exp_t e, logic [7:0] s, logic c);
    check({name, "_sum"}, 32'(s), 32'(e.sum));
    check({name, "_cout"}, 32'(c), 32'(e.cout));
    check({name, "_latency"}, 32'(cyc), 32'(e.edge_no));
  endtask

  task automatic spurious(string name);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_done: got done=1 expected done=0 (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every done pulse against the head of its queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (if0.done === 1'b1) begin
      if (q0.size() == 0) spurious("dut0");
      else begin e = q0.pop_front(); check_done("dut0", e, if0.sum, if0.cout); end
    end
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) spurious("dut1");
      else begin e = q1.pop_front(); check_done("dut1", e, if1.sum, if1.cout); end
    end
    if (if2.done === 1'b1) begin
      if (q2.size() == 0) spurious("dut2");
      else begin e = q2.pop_front(); check_done("dut2", e, {7'd0, if2.sum}, if2.cout); end
    end
  end

  task automatic start0(logic [7:0] a, logic [7:0] b, logic c, logic s, logic [7:0] es, logic ec);
    @(negedge clk);
    if0.start = 1'b1; if0.a = a; if0.b = b; if0.cin = c;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    if0.sub = s;
`else
    if (s) $display("note: sub requested without subtract support");
`endif
    q0.push_back('{es, ec, cyc + 1 + 8});
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  task automatic start1(logic [7:0] a, logic [7:0] b, logic c, logic [7:0] es, logic ec);
    @(negedge clk);
    if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = c;
    q1.push_back('{es, ec, cyc + 1 + 2});
    @(negedge clk);
    if1.start = 1'b0;
  endtask

  task automatic start2(logic a, logic b, logic c, logic es, logic ec);
    @(negedge clk);
    if2.start = 1'b1; if2.a = a; if2.b = b; if2.cin = c;
    q2.push_back('{{7'd0, es}, ec, cyc + 1 + 1});
    @(negedge clk);
    if2.start = 1'b0;
  endtask

  // Directed vectors: {a, b, cin, sum, cout}
  logic [25:0] vec0 [4] = '{
    {8'h12, 8'h34, 1'b1, 8'h47, 1'b0},
    {8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
    {8'h55, 8'hAA, 1'b1, 8'h00, 1'b1},
    {8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0}
  };
  logic [25:0] vec1 [4] = '{
    {8'h9C, 8'h77, 1'b1, 8'h14, 1'b1},
    {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
    {8'h00, 8'h00, 1'b0, 8'h00, 1'b0},
    {8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0}
  };
  // Full-adder truth table: {a, b, cin, sum, cout}
  logic [4:0] fa [8] = '{
    5'b000_0_0, 5'b001_1_0, 5'b010_1_0, 5'b011_0_1,
    5'b100_1_0, 5'b101_0_1, 5'b110_0_1, 5'b111_1_1
  };

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if0.start = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    if0.sub = 1'b0; if1.sub = 1'b0; if2.sub = 1'b0;
`endif

    // Reset then idle
    repeat (2) @(negedge clk);
    check("rst_dut1_sum", 32'(if1.sum), 32'h0);
    check("rst_dut2_busy", 32'(if2.busy), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(if0.busy), 32'h0);
      check("idle_done", 32'(if0.done), 32'h0);
      check("idle_sum", 32'(if0.sum), 32'h0);
      check("idle_cout", 32'(if0.cout), 32'h0);
    end

    // Carry ripple across all 8 bits
    start0(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    check("ripple_busy_e0", 32'(if0.busy), 32'h1);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("ripple_busy", 32'(if0.busy), 32'h1);
      check("ripple_done_early", 32'(if0.done), 32'h0);
      check("ripple_sum_hold", 32'(if0.sum), 32'h00);
      check("ripple_cout_hold", 32'(if0.cout), 32'h0);
    end
    @(negedge clk);
    check("ripple_busy_end", 32'(if0.busy), 32'h0);
    @(negedge clk);
    check("ripple_done_clear", 32'(if0.done), 32'h0);

    // Directed vectors on 8/1
    for (int i = 0; i < 4; i++) begin
      logic [25:0] v;
      v = vec0[i];
      start0(v[25:18], v[17:10], v[9], 1'b0, v[8:1], v[0]);
      repeat (8) @(negedge clk);
    end

    // Back-to-back with start held; mid-operation change of a is ignored
    @(negedge clk);
    begin
      int s;
      if0.start = 1'b1; if0.a = 8'h12; if0.b = 8'h34; if0.cin = 1'b1;
      s = cyc + 1;
      q0.push_back('{8'h47, 1'b0, s + 8});
      q0.push_back('{8'h47, 1'b0, s + 17});
      q0.push_back('{8'h47, 1'b0, s + 26});
      repeat (3) @(negedge clk);
      check("b2b_busy", 32'(if0.busy), 32'h1);
      if0.a = 8'hAA;
      repeat (3) @(negedge clk);
      if0.a = 8'h12;
      repeat (13) @(negedge clk);
      if0.start = 1'b0;
      repeat (9) @(negedge clk);
    end

    // Reset mid-operation discards the result
    start0(8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(if0.busy), 32'h0);
    check("midrst_sum", 32'(if0.sum), 32'h0);
    check("midrst_cout", 32'(if0.cout), 32'h0);
    check("midrst_done", 32'(if0.done), 32'h0);
    void'(q0.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_sum_after", 32'(if0.sum), 32'h0);
    check("midrst_busy_after", 32'(if0.busy), 32'h0);

    // Digit width 4
    for (int i = 0; i < 4; i++) begin
      logic [25:0] v;
      v = vec1[i];
      start1(v[25:18], v[17:10], v[9], v[8:1], v[0]);
      repeat (2) @(negedge clk);
    end

    // WIDTH = DIGIT = 1 full-adder sweep
    for (int i = 0; i < 8; i++) begin
      logic [4:0] v;
      v = fa[i];
      start2(v[4], v[3], v[2], v[1], v[0]);
      @(negedge clk);
    end

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    // Subtract mode
    start0(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    repeat (8) @(negedge clk);
    start0(8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1);
    repeat (8) @(negedge clk);
    start0(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);
    repeat (8) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("q0_pending", 32'(q0.size()), 32'h0);
    check("q1_pending", 32'(q1.size()), 32'h0);
    check("q2_pending", 32'(q2.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
